// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_if
// Description : Requester handshakes, register-file write port and decode
//               hazard signals for rf_write_arbiter. Bypass signals exist
//               only when RF_ARB_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          RegWrite;
    logic [AW-1:0] addD;
    logic [DW-1:0] WB_out;
    logic [AW-1:0] addA;
    logic [AW-1:0] addB;
    logic          hazard_a;
    logic          hazard_b;
`ifdef RF_ARB_BYPASS_EN
    logic          bypass_a_valid;
    logic [DW-1:0] bypass_a_data;
    logic          bypass_b_valid;
    logic [DW-1:0] bypass_b_data;
`endif

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output addA, addB,
        input  req0_ready, req1_ready,
        input  RegWrite, addD, WB_out,
`ifdef RF_ARB_BYPASS_EN
        input  bypass_a_valid, bypass_a_data, bypass_b_valid, bypass_b_data,
`endif
        input  hazard_a, hazard_b
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  addA, addB,
        output req0_ready, req1_ready,
        output RegWrite, addD, WB_out,
`ifdef RF_ARB_BYPASS_EN
        output bypass_a_valid, bypass_a_data, bypass_b_valid, bypass_b_data,
`endif
        output hazard_a, hazard_b
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Two one-entry write buffers round-robin arbitrated onto a
//               registered register-file write port, with RAW hazard flags.
//               Optional operand bypass outputs: define RF_ARB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_write_arbiter_if.slave  bus
);

    logic [1:0]    w_in_valid;
    logic [AW-1:0] w_in_addr [2];
    logic [DW-1:0] w_in_data [2];

    logic [1:0]    r_hold_v;
    logic [AW-1:0] r_hold_addr [2];
    logic [DW-1:0] r_hold_data [2];
    logic          r_rr;

    logic [1:0]    w_grant;
    logic [1:0]    w_ready;
    logic          w_sel;

    logic          r_reg_write;
    logic [AW-1:0] r_add_d;
    logic [DW-1:0] r_wb_out;

    assign w_in_valid   = {bus.req1_valid, bus.req0_valid};
    assign w_in_addr[0] = bus.req0_addr;
    assign w_in_addr[1] = bus.req1_addr;
    assign w_in_data[0] = bus.req0_data;
    assign w_in_data[1] = bus.req1_data;

    always_comb begin
        w_grant = r_hold_v;
        if (&r_hold_v) begin
            w_grant = r_rr ? 2'b10 : 2'b01;
        end
    end

    // A buffer being drained this cycle can accept its next write in parallel.
    assign w_ready        = ~r_hold_v | w_grant;
    assign w_sel          = w_grant[1];
    assign bus.req0_ready = w_ready[0];
    assign bus.req1_ready = w_ready[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                r_hold_addr[n] <= '0;
                r_hold_data[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_in_valid[n] && w_ready[n]) begin
                    r_hold_v[n]    <= 1'b1;
                    r_hold_addr[n] <= w_in_addr[n];
                    r_hold_data[n] <= w_in_data[n];
                end else if (w_grant[n]) begin
                    r_hold_v[n]    <= 1'b0;
                end
            end
        end
    end

    // Pointer moves only on a conflict, handing the next tie to the loser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= 1'b0;
        end else if (&r_hold_v) begin
            r_rr <= ~r_rr;
        end
    end

    // x0 writes consume the grant but never assert the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write <= 1'b0;
            r_add_d     <= '0;
            r_wb_out    <= '0;
        end else if (|w_grant) begin
            r_reg_write <= (r_hold_addr[w_sel] != '0);
            r_add_d     <= r_hold_addr[w_sel];
            r_wb_out    <= r_hold_data[w_sel];
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    assign bus.RegWrite = r_reg_write;
    assign bus.addD     = r_add_d;
    assign bus.WB_out   = r_wb_out;

    logic [1:0] w_buf_hit_a;
    logic [1:0] w_buf_hit_b;
    logic       w_ws_hit_a;
    logic       w_ws_hit_b;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_buf_hit_a[n] = r_hold_v[n] && (r_hold_addr[n] == bus.addA);
            w_buf_hit_b[n] = r_hold_v[n] && (r_hold_addr[n] == bus.addB);
        end
    end

    assign w_ws_hit_a   = r_reg_write && (r_add_d == bus.addA);
    assign w_ws_hit_b   = r_reg_write && (r_add_d == bus.addB);
    assign bus.hazard_a = (bus.addA != '0) && ((|w_buf_hit_a) || w_ws_hit_a);
    assign bus.hazard_b = (bus.addB != '0) && ((|w_buf_hit_b) || w_ws_hit_b);

`ifdef RF_ARB_BYPASS_EN
    // With both buffers matching, the entry granted second (~rr) is the newest.
    always_comb begin
        bus.bypass_a_valid = bus.hazard_a;
        if (w_ws_hit_a) begin
            bus.bypass_a_data = r_wb_out;
        end else if (&w_buf_hit_a) begin
            bus.bypass_a_data = r_hold_data[~r_rr];
        end else if (w_buf_hit_a[1]) begin
            bus.bypass_a_data = r_hold_data[1];
        end else begin
            bus.bypass_a_data = r_hold_data[0];
        end
    end

    always_comb begin
        bus.bypass_b_valid = bus.hazard_b;
        if (w_ws_hit_b) begin
            bus.bypass_b_data = r_wb_out;
        end else if (&w_buf_hit_b) begin
            bus.bypass_b_data = r_hold_data[~r_rr];
        end else if (w_buf_hit_b[1]) begin
            bus.bypass_b_data = r_hold_data[1];
        end else begin
            bus.bypass_b_data = r_hold_data[0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed self-checking bench for rf_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    rf_write_arbiter_if #(.AW(5), .DW(32)) bus ();

    rf_write_arbiter #(.AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.addA = 5'd5;
        bus.addB = 5'd6;
        rst_n = 1'b0;
        step();
        vectors++;
        if (bus.RegWrite !== 1'b0) begin
            miscompares++; $display("FAIL reset_regwrite: got %0b expected 0", bus.RegWrite);
        end
        vectors++;
        if (bus.addD !== 5'd0 || bus.WB_out !== 32'd0) begin
            miscompares++; $display("FAIL reset_port: got addD=%0d WB=%0h expected 0/0", bus.addD, bus.WB_out);
        end
        vectors++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready: got %0b%0b expected 11", bus.req1_ready, bus.req0_ready);
        end
        vectors++;
        if (bus.hazard_a !== 1'b0 || bus.hazard_b !== 1'b0) begin
            miscompares++; $display("FAIL reset_hazard: got %0b%0b expected 00", bus.hazard_b, bus.hazard_a);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd5;
        bus.req0_data  = 32'hDEADBEEF;
        #1;
        vectors++;
        if (bus.req0_ready !== 1'b1) begin
            miscompares++; $display("FAIL single_ready: got %0b expected 1", bus.req0_ready);
        end
        step();
        bus.req0_valid = 1'b0;
        vectors++;
        if (bus.RegWrite !== 1'b0) begin
            miscompares++; $display("FAIL single_early: got RegWrite=%0b expected 0", bus.RegWrite);
        end
        step();
        vectors++;
        if (bus.RegWrite !== 1'b1 || bus.addD !== 5'd5 || bus.WB_out !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL single_write: got %0b/%0d/%0h expected 1/5/deadbeef",
                                    bus.RegWrite, bus.addD, bus.WB_out);
        end
        step();
        vectors++;
        if (bus.RegWrite !== 1'b0) begin
            miscompares++; $display("FAIL single_drop: got RegWrite=%0b expected 0", bus.RegWrite);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] d0 [4];
        logic [31:0] d1 [4];
        logic        rdy0 [4];
        logic        rdy1 [4];
        logic        erw  [7];
        logic [4:0]  eadd [7];
        logic [31:0] ewb  [7];
        d0   = '{32'h100, 32'h101, 32'h102, 32'h102};
        d1   = '{32'h200, 32'h201, 32'h201, 32'h202};
        rdy0 = '{1'b1, 1'b1, 1'b0, 1'b1};
        rdy1 = '{1'b1, 1'b0, 1'b1, 1'b0};
        erw  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        eadd = '{5'd0, 5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd1};
        ewb  = '{32'h0, 32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h102};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = d0[k];
                bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = d1[k];
                #1;
                vectors++;
                if (bus.req0_ready !== rdy0[k] || bus.req1_ready !== rdy1[k]) begin
                    miscompares++; $display("FAIL conflict_ready[%0d]: got %0b%0b expected %0b%0b",
                                            k, bus.req1_ready, bus.req0_ready, rdy1[k], rdy0[k]);
                end
            end else begin
                clear_inputs();
            end
            step();
            vectors++;
            if (bus.RegWrite !== erw[k] || bus.addD !== eadd[k] || bus.WB_out !== ewb[k]) begin
                miscompares++; $display("FAIL conflict_write[%0d]: got %0b/%0d/%0h expected %0b/%0d/%0h",
                                        k, bus.RegWrite, bus.addD, bus.WB_out, erw[k], eadd[k], ewb[k]);
            end
        end
    endtask

    task automatic test_x0_write();
        clear_inputs();
        bus.addA = 5'd0;
        bus.addB = 5'd0;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 5'd0;
        bus.req1_data  = 32'h1234;
        #1;
        vectors++;
        if (bus.req1_ready !== 1'b1) begin
            miscompares++; $display("FAIL x0_ready: got %0b expected 1", bus.req1_ready);
        end
        step();
        bus.req1_valid = 1'b0;
        vectors++;
        if (bus.hazard_a !== 1'b0) begin
            miscompares++; $display("FAIL x0_hazard: got %0b expected 0", bus.hazard_a);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if (bus.RegWrite !== 1'b0 || bus.hazard_a !== 1'b0) begin
                miscompares++; $display("FAIL x0_regwrite[%0d]: got rw=%0b hz=%0b expected 0/0",
                                        k, bus.RegWrite, bus.hazard_a);
            end
        end
    endtask

    task automatic test_hazard();
        logic       ehz [3];
        logic       erw [3];
        ehz = '{1'b1, 1'b1, 1'b0};
        erw = '{1'b0, 1'b1, 1'b0};
        clear_inputs();
        bus.addA = 5'd7;
        bus.addB = 5'd9;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd7;
        bus.req0_data  = 32'h77;
        #1;
        vectors++;
        if (bus.hazard_a !== 1'b0) begin
            miscompares++; $display("FAIL hazard_pre: got %0b expected 0", bus.hazard_a);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            bus.req0_valid = 1'b0;
            vectors++;
            if (bus.hazard_a !== ehz[k] || bus.hazard_b !== 1'b0 || bus.RegWrite !== erw[k]) begin
                miscompares++; $display("FAIL hazard[%0d]: got a=%0b b=%0b rw=%0b expected %0b/0/%0b",
                                        k, bus.hazard_a, bus.hazard_b, bus.RegWrite, ehz[k], erw[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0   [5];
        logic        rdy0 [5];
        logic        erw  [5];
        logic [4:0]  eadd [5];
        logic [31:0] ewb  [5];
        d0   = '{32'h30, 32'h31, 32'h32, 32'h32, 32'h0};
        rdy0 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        erw  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        eadd = '{5'd0, 5'd3, 5'd4, 5'd3, 5'd3};
        ewb  = '{32'h0, 32'h30, 32'h40, 32'h31, 32'h32};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.req0_valid = (k < 4);
            bus.req0_addr  = 5'd3;
            bus.req0_data  = d0[k];
            bus.req1_valid = (k == 0);
            bus.req1_addr  = 5'd4;
            bus.req1_data  = 32'h40;
            #1;
            vectors++;
            if (bus.req0_ready !== rdy0[k]) begin
                miscompares++; $display("FAIL b2b_ready[%0d]: got %0b expected %0b", k, bus.req0_ready, rdy0[k]);
            end
            step();
            vectors++;
            if (bus.RegWrite !== erw[k] || bus.addD !== eadd[k] || bus.WB_out !== ewb[k]) begin
                miscompares++; $display("FAIL b2b_write[%0d]: got %0b/%0d/%0h expected %0b/%0d/%0h",
                                        k, bus.RegWrite, bus.addD, bus.WB_out, erw[k], eadd[k], ewb[k]);
            end
        end
        clear_inputs();
        step();
        vectors++;
        if (bus.RegWrite !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle: got %0b expected 0", bus.RegWrite);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd10; bus.req0_data = 32'hA;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd11; bus.req1_data = 32'hB;
        step();
        bus.req0_addr = 5'd12; bus.req0_data = 32'hC;
        step();
        clear_inputs();
        bus.addA = 5'd12;
        bus.addB = 5'd11;
        #1;
        vectors++;
        if (bus.RegWrite !== 1'b1 || bus.addD !== 5'd10 || bus.hazard_a !== 1'b1) begin
            miscompares++; $display("FAIL midop_pre: got rw=%0b addD=%0d hz=%0b expected 1/10/1",
                                    bus.RegWrite, bus.addD, bus.hazard_a);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.RegWrite !== 1'b0 || bus.addD !== 5'd0 || bus.WB_out !== 32'd0) begin
            miscompares++; $display("FAIL midop_async: got %0b/%0d/%0h expected 0/0/0",
                                    bus.RegWrite, bus.addD, bus.WB_out);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (bus.RegWrite !== 1'b0 || bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1 ||
                bus.hazard_a !== 1'b0 || bus.hazard_b !== 1'b0) begin
                miscompares++; $display("FAIL midop_after[%0d]: got rw=%0b rdy=%0b%0b hz=%0b%0b expected 0/11/00",
                                        k, bus.RegWrite, bus.req1_ready, bus.req0_ready,
                                        bus.hazard_b, bus.hazard_a);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.addA    = '0;
        bus.addB    = '0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_conflict();
        test_x0_write();
        test_hazard();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite, addD, WB_out) between two requesters.
  - Requester 0: core writeback.
  - Requester 1: multi-cycle unit (load or long-latency ALU result).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains one buffered write per cycle into a registered write-port stage.
- Exposes read-after-write hazard flags for the decode stage's two read addresses.

Parameters:
- AW, 5, register address width (32 architectural registers).
- DW, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 presents a write.
- req0_ready  output  1  requester 0 write accepted this cycle when valid & ready.
- req0_addr  input  AW  requester 0 destination register.
- req0_data  input  DW  requester 0 write data.
- req1_valid  input  1  requester 1 presents a write.
- req1_ready  output  1  requester 1 handshake ready.
- req1_addr  input  AW  requester 1 destination register.
- req1_data  input  DW  requester 1 write data.
- RegWrite  output  1  register-file write enable (registered).
- addD  output  AW  register-file write address (registered).
- WB_out  output  DW  register-file write data (registered).
- addA  input  AW  decode read address A, used for hazard check.
- addB  input  AW  decode read address B, used for hazard check.
- hazard_a  output  1  a pending write targets addA.
- hazard_b  output  1  a pending write targets addB.

Behaviour:
- Reset, asynchronous on rst_n low:
  - hold_v[1:0] = 0.
  - RegWrite = 0, addD = 0, WB_out = 0.
  - Round-robin pointer rr = 0 (requester 0 favoured first).
  - hazard_a/b = 0.
  - Reset mid-operation discards all buffered writes; nothing is written afterwards.
- Holding buffers:
  - reqN_ready = !hold_v[N] | grant[N] (combinational). A buffer can refill in the same cycle it drains.
  - On reqN_valid & reqN_ready at posedge, hold_v[N] = 1 and the addr/data are captured.
- Arbitration, combinational on hold_v:
  - Only one buffer valid: that buffer is granted.
  - Both valid: grant goes to rr. After such a conflict, rr flips to the other requester.
  - rr does not change on uncontended grants.
- Write stage:
  - At the posedge after a grant: RegWrite = 1 and addD/WB_out = the granted entry; the granted hold_v clears unless it refills the same cycle.
  - No grant: RegWrite = 0; addD/WB_out hold their previous values.
- Latency:
  - Handshake at edge N, buffer empty and uncontended: RegWrite high after edge N+1; the register file commits at edge N+2.
  - Under conflict, the loser waits exactly one extra cycle, so it is never starved.
- x0 writes:
  - Accepted and granted like any other write, which consumes the grant and affects rr.
  - RegWrite stays 0 for them.
  - They never raise a hazard.
- Hazards:
  - hazard_a = (addA != 0) & (any valid hold addr == addA, or RegWrite & addD == addA).
  - hazard_b is the same against addB.
  - Both are combinational from registered state only.
- Same address in both buffers: arbitration order decides the commit order; the later write wins in the register file.

Optional Feature:
- Macro RF_ARB_BYPASS_EN.
- Defined: adds outputs bypass_a_valid, bypass_a_data, bypass_b_valid, bypass_b_data, with the following precedence per read port:
  - The write-stage entry (RegWrite & addD match) supplies the data, as the newest committed-next value.
  - Otherwise the data comes from the holding buffer that will be granted last under the current rr.
  - Hazard flags are unchanged.
- Undefined: these ports and their logic are absent; the decode stage stalls on hazard flags alone.

Test Plan:
- Reset, then req0 writes addr 5, data 0xDEADBEEF → req0_ready = 1; RegWrite = 1, addD = 5, WB_out = 0xDEADBEEF one cycle later; RegWrite = 0 the next cycle.
- Both requesters valid every cycle (req0 addr 1, req1 addr 2) for 4 cycles → grants alternate 0,1,0,1; each ready deasserts while its buffer waits; no write is lost.
- req1 writes addr 0, data 0x1234 → handshake completes; RegWrite stays 0; hazard_a = 0 with addA = 0.
- req0 writes addr 7, addA = 7 → hazard_a = 1 from the cycle after the handshake until the cycle after RegWrite pulses; hazard_b = 0 with addB = 9.
- Buffer 0 full and losing arbitration, req0_valid held → req0_ready = 0 for one cycle, then 1 in its grant cycle with the new entry captured back-to-back.
- Assert rst_n low while both buffers are full → RegWrite = 0 immediately; after release there are no writes and both readies are 1.
